// File: rtl/rx_lvds.sv
// rx_lvds: single-wire serial receiver for the LVDS link.
// Frame: idle high, start bit (0), DATA_W data bits LSB first, stop bit (1).
// The receiver takes one sample per bit, on every rising edge of clk.
// Each good word is presented on data_out, with a one-cycle data_valid strobe.
// A stop bit sampled as 0 raises a one-cycle frame_err strobe and drops the word.
// Optional feature, macro RX_LVDS_SYNC_EN: rx first passes through a two-flop
// synchronizer whose flops reset to 1. This adds two cycles to every timing.
module rx_lvds #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              rx_busy
);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_DATA      = 2'd2,
        ST_STOP      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              rx_s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

`ifdef RX_LVDS_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer. Resetting it to 1 makes it look like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    // Next-state logic and output strobes. Strobes default to 0 every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                // A low line here is ignored until the line returns high.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                // LSB arrives first, so each sample enters at the top and shifts down.
                shift_d = {rx_s, shift_q[DATA_W-1:1]};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                // Going straight back to IDLE lets a start bit on the next edge be accepted.
                if (rx_s) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
        busy_d = (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            shift_q <= {DATA_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_rx_lvds.sv
// tb_rx_lvds: directed and random frames for rx_lvds, checked every cycle
// against a frame-level parser of the line bit stream.
module tb_rx_lvds;

    localparam int W    = 24;
    localparam int MAXN = 2048;
`ifdef RX_LVDS_SYNC_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx    = 1'b1;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         rx_busy;

    int checks   = 0;
    int failures = 0;

    bit           line[$];
    bit           eff[$];
    bit           e_valid[MAXN];
    bit           e_err[MAXN];
    bit           e_busy[MAXN];
    logic [W-1:0] e_word[MAXN];
    logic [W-1:0] e_dout[MAXN];

    rx_lvds #(.DATA_W(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_ones(input int n);
        for (int i = 0; i < n; i++) line.push_back(1'b1);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) line.push_back(1'b0);
    endtask

    task automatic push_frame(input logic [W-1:0] w, input bit stop);
        line.push_back(1'b0);
        for (int i = 0; i < W; i++) line.push_back(w[i]);
        line.push_back(stop);
    endtask

    // Parse the stream the receiver sees at each edge into expected per-edge
    // outputs. eff[k] is the line value seen at edge k, after any synchronizer delay.
    function automatic void build_model();
        int  n;
        int  k;
        int  s;
        bit  waiting;
        logic [W-1:0] word;
        logic [W-1:0] cur;
        eff = {};
        for (int i = 0; i < LAT; i++) eff.push_back(1'b1);
        foreach (line[i]) eff.push_back(line[i]);
        n = eff.size();
        for (int i = 0; i < MAXN; i++) begin
            e_valid[i] = 1'b0;
            e_err[i]   = 1'b0;
            e_busy[i]  = 1'b0;
            e_word[i]  = '0;
        end
        k = 0;
        waiting = 1'b1;
        while (k < n) begin
            if (waiting) begin
                if (eff[k]) waiting = 1'b0;
                k++;
            end else if (eff[k]) begin
                k++;
            end else begin
                s = k;
                if (s + W + 1 >= n) begin
                    for (int j = s; j < n; j++) e_busy[j] = 1'b1;
                    k = n;
                end else begin
                    word = '0;
                    for (int i = 0; i < W; i++) word[i] = eff[s + 1 + i];
                    for (int j = s; j <= s + W; j++) e_busy[j] = 1'b1;
                    if (eff[s + W + 1]) begin
                        e_valid[s + W + 1] = 1'b1;
                        e_word[s + W + 1]  = word;
                    end else begin
                        e_err[s + W + 1] = 1'b1;
                        waiting = 1'b1;
                    end
                    k = s + W + 2;
                end
            end
        end
        cur = '0;
        for (int i = 0; i < n; i++) begin
            if (e_valid[i]) cur = e_word[i];
            e_dout[i] = cur;
        end
    endfunction

    // Pulse reset and check the cleared outputs. Then drive the line one bit
    // per cycle and compare the outputs after every edge.
    task automatic run_segment(input string name);
        if (line.size() + LAT > MAXN) begin
            $display("FAIL %s segment too long: %0d bits, limit %0d", name, line.size(), MAXN);
            $fatal(1, "segment overflow");
        end
        build_model();
        @(negedge clk);
        rst_n = 1'b0;
        rx    = line[0];
        #1;
        check({name, ".rst_dout"},  32'(data_out),   32'h0);
        check({name, ".rst_valid"}, 32'(data_valid), 32'h0);
        check({name, ".rst_err"},   32'(frame_err),  32'h0);
        check({name, ".rst_busy"},  32'(rx_busy),    32'h0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < line.size(); k++) begin
            rx = line[k];
            @(posedge clk);
            #1;
            check($sformatf("%s.valid@%0d", name, k), 32'(data_valid), 32'(e_valid[k]));
            check($sformatf("%s.err@%0d",   name, k), 32'(frame_err),  32'(e_err[k]));
            check($sformatf("%s.busy@%0d",  name, k), 32'(rx_busy),    32'(e_busy[k]));
            check($sformatf("%s.dout@%0d",  name, k), 32'(data_out),   32'(e_dout[k]));
        end
        line = {};
    endtask

    initial begin
        int nfr;

        // Single frame.
        push_ones(3);
        push_frame(24'hA5C3F1, 1'b1);
        push_ones(3);
        run_segment("single");

        // Back-to-back frames with only the stop bit between them.
        push_ones(2);
        push_frame(24'h000001, 1'b1);
        push_frame(24'hFFFFFE, 1'b1);
        push_ones(3);
        run_segment("b2b");

        // Framing error: data_out keeps 0x111111, and the low line is not decoded.
        push_ones(2);
        push_frame(24'h111111, 1'b1);
        push_frame(24'h123456, 1'b0);
        push_zeros(5);
        push_ones(2);
        push_frame(24'h654321, 1'b1);
        push_ones(3);
        run_segment("ferr");

        // Good frame, then a frame cut off after 10 data bits by the next reset.
        push_ones(2);
        push_frame(24'h5A5A5A, 1'b1);
        push_ones(1);
        line.push_back(1'b0);
        push_ones(10);
        run_segment("midfrm");

        // After the mid-frame reset: 14 low cycles, then line high, then a frame.
        push_zeros(14);
        push_ones(2);
        push_frame(24'h00ABCD, 1'b1);
        push_ones(3);
        run_segment("after_rst");

        // All-zero and all-one data words.
        push_ones(2);
        push_frame(24'h000000, 1'b1);
        push_ones(1);
        push_frame(24'hFFFFFF, 1'b1);
        push_ones(3);
        run_segment("bound");

        // Random words, random gaps, occasional framing errors.
        push_ones(2);
        nfr = 14;
        for (int f = 0; f < nfr; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                push_frame(W'($urandom), 1'b0);
                push_zeros($urandom_range(0, 3));
                push_ones($urandom_range(1, 2));
            end else begin
                push_frame(W'($urandom), 1'b1);
                push_ones($urandom_range(0, 3));
            end
        end
        push_ones(3);
        run_segment("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
